// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants and helpers for the 3x3 convolution path (window generator
// and 3x3 MAC). Both blocks agree on the 72-bit window byte packing defined by
// win_idx().
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_DIM = 3;
    localparam int WIN_W   = WIN_DIM * WIN_DIM * PIX_W;

    // LSB position of tap (r,c) inside the packed window. Tap (0,0) is the
    // oldest row / leftmost column and sits in the top byte; tap (2,2) is the
    // newest pixel and sits in the bottom byte.
    function automatic int win_idx(input int r, input int c);
        return (8 - (WIN_DIM * r + c)) * PIX_W;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// -----------------------------------------------------------------------------
// conv_line_buf
// Single-port register-array line buffer holding one image row.
// Read is combinational from the addressed entry, so a read and a write to the
// same address in one cycle returns the old contents (read-before-write).
// Contents are not reset; they are always written before being consumed.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   addr   in   entry address (shared by read and write)
//   wdata  in   write data
//   rdata  out  current contents of entry addr
// -----------------------------------------------------------------------------
module conv_line_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; no reset on the data array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Asynchronous read gives old data on a same-address write cycle.
    always_comb begin
        rdata = mem_r[addr];
    end

endmodule

// File: rtl/conv3_window_gen.sv
// -----------------------------------------------------------------------------
// conv3_window_gen
// Streaming 3x3 window generator. Consumes a raster-order 8-bit pixel stream,
// keeps the two previous rows in line buffers and emits one packed 72-bit
// window per valid (unpadded) output position, one cycle after the pixel that
// completes it is accepted.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   frame_clr  in   synchronous frame abort (drops counters and held window)
//   in_valid   in   pixel present
//   in_ready   out  pixel accepted when in_valid & in_ready
//   in_data    in   pixel, raster order
//   out_valid  out  window present
//   out_ready  in   consumer takes window when out_valid & out_ready
//   out_win    out  packed window, [71:64]=P(r-2,c-2) ... [7:0]=P(r,c)
//   out_last   out  last window of the frame
// -----------------------------------------------------------------------------
module conv3_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_win,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [CW-1:0]    col_r;
    logic [RW-1:0]    row_r;
    logic [PIX_W-1:0] tap_r   [WIN_DIM][WIN_DIM];
    logic [PIX_W-1:0] tap_nxt_s [WIN_DIM][WIN_DIM];
    logic [WIN_W-1:0] win_pack_s;
    logic [PIX_W-1:0] lb1_rd_s;
    logic [PIX_W-1:0] lb2_rd_s;
    logic             accept_s;
    logic             emit_s;
    logic             col_ok_s;
    logic             row_ok_s;
    logic             is_last_s;
    logic             col_wrap_s;

    // Handshake and position decode. Positions are tested by equality only:
    // "col >= 2" is expressed as "col is neither 0 nor 1".
    always_comb begin
        in_ready   = !out_valid || out_ready;
        accept_s   = in_valid && in_ready && !frame_clr;
        col_ok_s   = (col_r != '0) && (col_r != COL_ONE);
        row_ok_s   = (row_r != '0) && (row_r != ROW_ONE);
        emit_s     = accept_s && col_ok_s && row_ok_s;
        col_wrap_s = (col_r == COL_LAST);
        is_last_s  = (row_r == ROW_LAST) && col_wrap_s;
    end

    // Row r-1 buffer: takes the incoming pixel.
    conv_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept_s),
        .addr  (col_r),
        .wdata (in_data),
        .rdata (lb1_rd_s)
    );

    // Row r-2 buffer: takes the pixel being displaced from lb1.
    conv_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb2 (
        .clk   (clk),
        .we    (accept_s),
        .addr  (col_r),
        .wdata (lb1_rd_s),
        .rdata (lb2_rd_s)
    );

    // Next shift-register contents: shift one column left, new right column
    // is {row r-2, row r-1, row r} at the current column.
    always_comb begin
        for (int r = 0; r < WIN_DIM; r++) begin
            tap_nxt_s[r][0] = tap_r[r][1];
            tap_nxt_s[r][1] = tap_r[r][2];
        end
        tap_nxt_s[0][2] = lb2_rd_s;
        tap_nxt_s[1][2] = lb1_rd_s;
        tap_nxt_s[2][2] = in_data;
    end

    // Pack the next window into the shared 72-bit byte layout.
    always_comb begin
        win_pack_s = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                win_pack_s[win_idx(r, c) +: PIX_W] = tap_nxt_s[r][c];
            end
        end
    end

    // Raster position counters; frame_clr acts as the synchronous soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= '0;
            row_r <= '0;
        end else if (frame_clr) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_wrap_s) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // 3x3 shift register; stale columns from the previous row are pushed out
    // by the first two pixels of each row before any window is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    tap_r[r][c] <= '0;
                end
            end
        end else if (accept_s) begin
            tap_r <= tap_nxt_s;
        end else begin
            tap_r <= tap_r;
        end
    end

    // One-entry output register with same-cycle consume-and-reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
        end else if (frame_clr) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= out_win;
        end else if (emit_s) begin
            out_valid <= 1'b1;
            out_last  <= is_last_s;
            out_win   <= win_pack_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= out_win;
        end else begin
            out_valid <= out_valid;
            out_last  <= out_last;
            out_win   <= out_win;
        end
    end

endmodule

// File: tb/tb_conv3_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv3_window_gen
// Self-checking bench for conv3_window_gen (IMG_W=4, IMG_H=4). A reference
// model stores each accepted pixel in a frame array and, when a window position
// completes, pushes {last, window} to a scoreboard queue; the DUT output head
// is compared with the queue front and popped on consume.
// -----------------------------------------------------------------------------
module tb_conv3_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    logic        clk;
    logic        rst_n;
    logic        frame_clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_win;
    logic        out_last;

    conv3_window_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_clr (frame_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          mr;
    int          mc;
    logic        last_acc;
    logic [7:0]  pix [IMG_H][IMG_W];
    logic [72:0] sb_q [$];
    logic [72:0] log_q [$];
    logic [72:0] exp_t1 [4];

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] model_win(input int r, input int c, input logic lst);
        return {lst,
                pix[r-2][c-2], pix[r-2][c-1], pix[r-2][c],
                pix[r-1][c-2], pix[r-1][c-1], pix[r-1][c],
                pix[r][c-2],   pix[r][c-1],   pix[r][c]};
    endfunction

    task automatic model_reset();
        mr = 0;
        mc = 0;
        sb_q.delete();
    endtask

    // One clock: drive at negedge, check, update model, advance to next negedge.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        frame_clr = clr;
        #1;
        chk("out_valid", {72'd0, out_valid}, {72'd0, (sb_q.size() != 0)});
        chk("in_ready", {72'd0, in_ready}, {72'd0, ((sb_q.size() == 0) || ordy)});
        if (out_valid && (sb_q.size() != 0)) begin
            chk("win_head", {out_last, out_win}, sb_q[0]);
        end
        last_acc = iv && in_ready && !clr;
        if (clr) begin
            model_reset();
        end else begin
            if (out_valid && ordy && (sb_q.size() != 0)) begin
                log_q.push_back(sb_q.pop_front());
            end
            if (last_acc) begin
                pix[mr][mc] = d;
                if (mr >= 2 && mc >= 2) begin
                    sb_q.push_back(model_win(mr, mc, (mr == IMG_H-1) && (mc == IMG_W-1)));
                end
                if (mc == IMG_W-1) begin
                    mc = 0;
                    mr = (mr == IMG_H-1) ? 0 : mr + 1;
                end else begin
                    mc = mc + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Accept n pixels with given valid/ready percentages; bounded.
    task automatic run_px(input int n, input int pv, input int pr, input logic rnd);
        int got;
        int guard;
        logic iv;
        logic ordy;
        logic [7:0] d;
        got = 0;
        guard = 0;
        while (got < n && guard < 4000) begin
            iv   = ($urandom_range(99) < pv);
            ordy = ($urandom_range(99) < pr);
            d    = rnd ? 8'($urandom) : 8'(mr * IMG_W + mc + 1);
            cycle(iv, d, ordy, 1'b0);
            if (last_acc) got++;
            guard++;
        end
        chk("stream_budget", 73'(got), 73'(n));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            cycle(1'b0, 8'd0, 1'b1, 1'b0);
            guard++;
        end
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        chk("drain_empty", 73'(sb_q.size()), 73'd0);
    endtask

    // Compare logged windows against the fixed 1..16 frame windows.
    task automatic check_frames(input string tag, input int nwin);
        chk(tag, 73'(log_q.size()), 73'(nwin));
        for (int i = 0; i < log_q.size() && i < nwin; i++) begin
            chk(tag, log_q[i], exp_t1[i % 4]);
        end
    endtask

    initial begin
        int nlast;
        checks    = 0;
        failures  = 0;
        exp_t1[0] = {1'b0, 72'h01_02_03_05_06_07_09_0A_0B};
        exp_t1[1] = {1'b0, 72'h02_03_04_06_07_08_0A_0B_0C};
        exp_t1[2] = {1'b0, 72'h05_06_07_09_0A_0B_0D_0E_0F};
        exp_t1[3] = {1'b1, 72'h06_07_08_0A_0B_0C_0E_0F_10};
        rst_n     = 1'b0;
        frame_clr = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        last_acc  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {72'd0, out_valid}, 73'd0);
        chk("rst_out_last", {72'd0, out_last}, 73'd0);
        chk("rst_out_win", {1'b0, out_win}, 73'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single frame, full throughput.
        log_q.delete();
        run_px(11, 100, 100, 1'b0);
        chk("first_valid", {72'd0, out_valid}, 73'd1);
        chk("first_win", {out_last, out_win}, exp_t1[0]);
        run_px(5, 100, 100, 1'b0);
        drain();
        check_frames("t1_win", 4);

        // Test 2: backpressure holds the first window.
        log_q.delete();
        run_px(11, 100, 100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_win", {out_last, out_win}, exp_t1[0]);
            cycle(1'b1, 8'(mr * IMG_W + mc + 1), 1'b0, 1'b0);
            chk("hold_no_accept", {72'd0, last_acc}, 73'd0);
        end
        run_px(5, 100, 100, 1'b0);
        drain();
        check_frames("t2_win", 4);

        // Test 3: two frames back to back.
        log_q.delete();
        run_px(32, 100, 100, 1'b0);
        drain();
        check_frames("t3_win", 8);

        // Test 4: random handshakes and data over three frames.
        log_q.delete();
        run_px(48, 70, 60, 1'b1);
        drain();
        chk("t4_count", 73'(log_q.size()), 73'd12);
        nlast = 0;
        foreach (log_q[i]) if (log_q[i][72]) nlast++;
        chk("t4_lasts", 73'(nlast), 73'd3);

        // Test 5: frame abort after 9 pixels, then a clean frame.
        log_q.delete();
        run_px(9, 100, 100, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        run_px(16, 100, 100, 1'b0);
        drain();
        check_frames("t5_win", 4);

        // Test 6: async reset while a window is held.
        log_q.delete();
        run_px(12, 100, 100, 1'b0);
        cycle(1'b1, 8'(mr * IMG_W + mc + 1), 1'b0, 1'b0);
        chk("t6_pre_valid", {72'd0, out_valid}, 73'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {72'd0, out_valid}, 73'd0);
        chk("t6_async_last", {72'd0, out_last}, 73'd0);
        chk("t6_async_win", {1'b0, out_win}, 73'd0);
        model_reset();
        log_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_px(16, 100, 100, 1'b0);
        drain();
        check_frames("t6_win", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
